// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// default program-length limit and the byte/word widths of the load stream.
package program_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int unsigned DEF_MAX_WORDS = 1024;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WR,
    S_SUM_HI,
    S_SUM_LO,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in and memory write port out; the loader sits on the slave side.
// In_Ready is the only backpressure path; the memory write port has none.
interface program_loader_if #(parameter int ADDR_W = 16);
  import program_loader_pkg::*;

  logic [BYTE_W-1:0] In_Data;
  logic              In_Valid;
  logic              In_Ready;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [WORD_W-1:0] Mem_Data;
  logic              Mem_Write;

  modport master (
    output In_Data, In_Valid,
    input  In_Ready, Mem_Addr, Mem_Data, Mem_Write
  );

  modport slave (
    input  In_Data, In_Valid,
    output In_Ready, Mem_Addr, Mem_Data, Mem_Write
  );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Byte-pair to big-endian word assembler: latches the high byte, presents the word
// combinationally with the low byte in the same cycle it transfers (zero latency, no backpressure).
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              xfer,
  input  logic              sel_lo,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic [WORD_W-1:0] word_dat,
  output logic              word_vld
);

  logic [BYTE_W-1:0] hi_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_q <= '0;
    end else if (xfer && !sel_lo) begin
      hi_q <= byte_dat;
    end
  end

  // The low byte never needs storing: the FSM consumes the word on the same edge.
  assign word_dat = {hi_q, byte_dat};
  assign word_vld = xfer & sel_lo;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed big-endian word stream into processor memory.
// Min 3*L+4 cycles per load; In_Ready drops during the write cycle and after DONE/ERR.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  program_loader_if.slave  bus,
  output logic             CPU_RST,
  output logic             Done,
  output logic             Err
);

  state_t            state;
  logic [WORD_W-1:0] len_q;
  logic [WORD_W-1:0] sum_q;
  logic [WORD_W-1:0] word_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [WORD_W-1:0] word_dat;
  logic              word_vld;
  logic              xfer;
  logic              sel_lo;

  assign xfer   = bus.In_Valid & bus.In_Ready;
  assign sel_lo = (state == S_LEN_LO) || (state == S_DAT_LO) || (state == S_SUM_LO);

  byte_assembler u_asm (
    .CLK      (CLK),
    .RST      (RST),
    .xfer     (xfer),
    .sel_lo   (sel_lo),
    .byte_dat (bus.In_Data),
    .word_dat (word_dat),
    .word_vld (word_vld)
  );

  // Outputs are registered alongside each state transition so they track the state exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      len_q        <= '0;
      sum_q        <= '0;
      word_cnt     <= '0;
      addr_cnt     <= '0;
      bus.In_Ready <= 1'b0;
      bus.Mem_Write <= 1'b0;
      bus.Mem_Addr <= '0;
      bus.Mem_Data <= '0;
      CPU_RST      <= 1'b1;
      Done         <= 1'b0;
      Err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) begin
            state        <= S_LEN_HI;
            sum_q        <= '0;
            word_cnt     <= '0;
            addr_cnt     <= '0;
            bus.In_Ready <= 1'b1;
            CPU_RST      <= 1'b1;
            Done         <= 1'b0;
            Err          <= 1'b0;
          end
        end
        S_LEN_HI: if (xfer) state <= S_LEN_LO;
        S_LEN_LO: begin
          if (word_vld) begin
            len_q <= word_dat;
            if (word_dat == '0) begin
              state <= S_SUM_HI;
            end else if (32'(word_dat) > MAX_WORDS) begin
              state        <= S_ERR;
              bus.In_Ready <= 1'b0;
              Err          <= 1'b1;
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: if (xfer) state <= S_DAT_LO;
        S_DAT_LO: begin
          if (word_vld) begin
            state         <= S_WR;
            bus.In_Ready  <= 1'b0;
            bus.Mem_Write <= 1'b1;
            bus.Mem_Addr  <= addr_cnt;
            bus.Mem_Data  <= word_dat;
            sum_q         <= sum_q + word_dat;
          end
        end
        S_WR: begin
          bus.Mem_Write <= 1'b0;
          bus.In_Ready  <= 1'b1;
          addr_cnt      <= addr_cnt + ADDR_W'(1);
          word_cnt      <= word_cnt + 16'd1;
          state         <= (word_cnt + 16'd1 == len_q) ? S_SUM_HI : S_DAT_HI;
        end
        S_SUM_HI: if (xfer) state <= S_SUM_LO;
        S_SUM_LO: begin
          if (word_vld) begin
            bus.In_Ready <= 1'b0;
            if (word_dat == sum_q) begin
              state   <= S_DONE;
              Done    <= 1'b1;
              CPU_RST <= 1'b0;
            end else begin
              state <= S_ERR;
              Err   <= 1'b1;
            end
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.In_Ready  <= 1'b0;
          bus.Mem_Write <= 1'b0;
          CPU_RST       <= 1'b1;
          Done          <= 1'b0;
          Err           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a stream-level reference model.
module tb_program_loader;
  localparam int          ADDR_W = 16;
  localparam int unsigned MAXW   = 1024;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic RST, Start, CPU_RST, Done, Err;

  program_loader_if #(.ADDR_W(ADDR_W)) bus();

  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .bus     (bus),
    .CPU_RST (CPU_RST),
    .Done    (Done),
    .Err     (Err)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  wr_t         obs[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.Mem_Write === 1'b1) obs.push_back('{bus.Mem_Addr, bus.Mem_Data});
  end

  // Reference: parse the word stream by its rules and predict writes and outcome.
  task automatic model(input logic [15:0] w[$], output wr_t exp[$], output bit ok, output int used);
    logic [15:0] sum;
    int L;
    sum = 16'h0;
    L   = int'(w[0]);
    exp = {};
    if (L > int'(MAXW)) begin
      ok = 1'b0;
      used = 1;
      return;
    end
    for (int i = 0; i < L; i++) begin
      exp.push_back('{i[15:0], w[1+i]});
      sum = sum + w[1+i];
    end
    ok   = (w[L+1] == sum);
    used = L + 2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, inout bit tmo);
    int n;
    n = 0;
    if (tmo) return;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
    bus.In_Valid = 1'b1;
    bus.In_Data  = b;
    while (bus.In_Ready !== 1'b1) begin
      @(posedge CLK); #1;
      n++;
      if (n > 50) begin
        tmo = 1'b1;
        bus.In_Valid = 1'b0;
        return;
      end
    end
    @(posedge CLK); #1;
    bus.In_Valid = 1'b0;
    bus.In_Data  = 8'($urandom);
  endtask

  task automatic run_stream(input string name, input logic [15:0] w[$], input bit gaps,
                            input bit start_noise, input bit chk_time);
    wr_t         exp[$];
    bit          ok;
    bit          tmo;
    int          used;
    int          n;
    int unsigned t0;
    tmo = 1'b0;
    model(w, exp, ok, used);
    obs = {};
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < used; i++) begin
      Start = (start_noise && i > 0 && i < used - 1) ? 1'($urandom) : 1'b0;
      send_byte(w[i][15:8], gaps, tmo);
      send_byte(w[i][7:0], gaps, tmo);
    end
    Start = 1'b0;
    n = 0;
    while (!(Done === 1'b1 || Err === 1'b1) && n < 20) begin @(posedge CLK); #1; n++; end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL %s in_ready_timeout got=%0b want=0", name, tmo); end
    if (chk_time && ok) begin
      checks++;
      if (cyc - t0 != 3 * int'(w[0]) + 4) begin
        errors++; $display("FAIL %s load_cycles got=%0d want=%0d", name, cyc - t0, 3 * int'(w[0]) + 4);
      end
    end
    repeat (3) begin @(posedge CLK); #1; end
    checks++; if (Done !== ok)  begin errors++; $display("FAIL %s done got=%b want=%b", name, Done, ok); end
    checks++; if (Err !== !ok)  begin errors++; $display("FAIL %s err got=%b want=%b", name, Err, !ok); end
    checks++; if (CPU_RST !== !ok) begin errors++; $display("FAIL %s cpu_rst got=%b want=%b", name, CPU_RST, !ok); end
    checks++; if (bus.In_Ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_after got=%b want=0", name, bus.In_Ready); end
    checks++;
    if (obs.size() != exp.size()) begin
      errors++; $display("FAIL %s write_count got=%0d want=%0d", name, obs.size(), exp.size());
    end else begin
      foreach (exp[k]) begin
        checks++;
        if (obs[k].addr !== exp[k].addr || obs[k].data !== exp[k].data) begin
          errors++;
          $display("FAIL %s write[%0d] got=%h:%h want=%h:%h", name, k, obs[k].addr, obs[k].data, exp[k].addr, exp[k].data);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++; if (bus.In_Ready !== 1'b0)  begin errors++; $display("FAIL %s in_ready got=%b want=0", name, bus.In_Ready); end
    checks++; if (bus.Mem_Write !== 1'b0) begin errors++; $display("FAIL %s mem_write got=%b want=0", name, bus.Mem_Write); end
    checks++; if (bus.Mem_Addr !== 16'h0) begin errors++; $display("FAIL %s mem_addr got=%h want=0", name, bus.Mem_Addr); end
    checks++; if (bus.Mem_Data !== 16'h0) begin errors++; $display("FAIL %s mem_data got=%h want=0", name, bus.Mem_Data); end
    checks++; if (Done !== 1'b0)          begin errors++; $display("FAIL %s done got=%b want=0", name, Done); end
    checks++; if (Err !== 1'b0)           begin errors++; $display("FAIL %s err got=%b want=0", name, Err); end
    checks++; if (CPU_RST !== 1'b1)       begin errors++; $display("FAIL %s cpu_rst got=%b want=1", name, CPU_RST); end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; bus.In_Valid = 1'b0; bus.In_Data = 8'h0;
    repeat (2) begin @(posedge CLK); #1; end
    check_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    logic [15:0] w[$];
    w = {16'h0003, 16'h1001, 16'h2002, 16'h3003, 16'h6006};
    run_stream("good3", w, 1'b0, 1'b0, 1'b1);
    w = {16'h0003, 16'h1001, 16'h2002, 16'h3003, 16'h6007};
    run_stream("badsum3", w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_length_limits();
    logic [15:0] w[$];
    logic [15:0] s;
    w = {16'h0401};
    run_stream("len_too_big", w, 1'b0, 1'b0, 1'b0);
    w = {16'h0000, 16'h0000};
    run_stream("len0_ok", w, 1'b0, 1'b0, 1'b1);
    w = {16'h0000, 16'h0001};
    run_stream("len0_bad", w, 1'b0, 1'b0, 1'b0);
    w = {16'h0400};
    s = 16'h0;
    for (int i = 0; i < 1024; i++) begin
      w.push_back(16'($urandom));
      s = s + w[$];
    end
    w.push_back(s);
    run_stream("len_max", w, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_valid_gaps();
    logic [15:0] w[$];
    w = {16'h0002, 16'($urandom), 16'($urandom)};
    w.push_back(w[1] + w[2]);
    run_stream("gapfree2", w, 1'b0, 1'b0, 1'b1);
    run_stream("gapped2", w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    logic [15:0] s;
    int          L;
    for (int it = 0; it < 8; it++) begin
      L = $urandom_range(1, 8);
      w = {16'(L)};
      s = 16'h0;
      for (int i = 0; i < L; i++) begin
        w.push_back(16'($urandom));
        s = s + w[$];
      end
      if ($urandom_range(0, 2) == 0) s = s ^ 16'(1 << $urandom_range(0, 15));
      w.push_back(s);
      run_stream($sformatf("rand%0d", it), w, 1'($urandom), 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w[$];
    bit tmo;
    tmo = 1'b0;
    obs = {};
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    send_byte(8'h00, 1'b0, tmo);
    send_byte(8'h03, 1'b0, tmo);
    send_byte(8'h11, 1'b0, tmo);
    send_byte(8'h22, 1'b0, tmo);
    send_byte(8'h33, 1'b0, tmo);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_reset_outputs("rst_mid");
    bus.In_Valid = 1'b1;
    bus.In_Data  = 8'h44;
    repeat (3) begin @(posedge CLK); #1; end
    bus.In_Valid = 1'b0;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rst_mid feed_timeout got=%0b want=0", tmo); end
    checks++;
    if (obs.size() != 1) begin
      errors++; $display("FAIL rst_mid partial_write_count got=%0d want=1", obs.size());
    end else begin
      checks++;
      if (obs[0].data !== 16'h1122) begin
        errors++; $display("FAIL rst_mid first_write got=%h want=1122", obs[0].data);
      end
    end
    w = {16'h0002, 16'hABCD, 16'h1234};
    w.push_back(w[1] + w[2]);
    run_stream("after_rst", w, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_length_limits();
    test_valid_gaps();
    test_random();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
